uart_tx_arbiter: RTL and testbench

Frame scheduler that shares the single `uart_tx` serializer between up to 16 requesters, such as BIP accumulator dump, PC/status dump and debug taps. Each granted request sends one frame over `uart_tx`: a header byte identifying the requester, then the data word LSB-first. The block selects requesters round-robin, drives `i_tx_start`/`i_din` and paces bytes on `o_tx_done`. It sits between the BIP-side producers and `uart_tx`, replacing ad-hoc per-producer send sequencers.

---
 rtl/uart_arb_pkg.sv | 26 ++
 rtl/uart_tx_arbiter_rr_arbiter.sv | 50 +++++
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart_tx frame scheduler: FSM states, header tag, id width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_arb_pkg;

    // Frame scheduler states; IDLE must stay the all-zero encoding so that
    // reset and "not busy" coincide.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    // Upper nibble of every header byte; the lower nibble carries the requester id.
    localparam logic [3:0] HDR_TAG = 4'hA;

    // Requester id width; the header has room for 16 requesters.
    localparam int ID_W = 4;

    // Header byte announcing which requester owns the frame.
    function automatic logic [7:0] hdr_byte(input logic [ID_W-1:0] id);
        return {HDR_TAG, id};
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin priority pick: first set request at or after ptr, wrapping modulo NREQ.
// Latency: purely combinational.
// Backpressure: none; the parent only samples the pick while idle.
//
// Ports:
//   req     - per-requester request levels
//   ptr     - index with highest priority this round (must be < NREQ)
//   grant   - one-hot grant, all-zero when no request is pending
//   id      - encoded index of the granted requester
//   any_req - high when some request is pending
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] id,
    output logic            any_req
);

    logic found;

    // Two passes over the request vector: the first only considers indices at
    // or above the pointer, the second (lowest index first) covers the wrap.
    // The first hit across both passes wins.
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                id       = j[ID_W-1:0];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                id       = j[ID_W-1:0];
            end
        end
    end

    assign any_req = found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among NREQ requesters; one frame per grant:
// header {A,id}, data bytes LSB first, plus an XOR checksum byte when
// UART_ARB_CHECKSUM_EN is defined.
// Latency: header start 2 edges after the request is sampled; next byte start
// 2 cycles after tx_done; ack 1 cycle after the final tx_done.
// Backpressure: bytes are paced by i_tx_done; requesters hold i_req until o_ack.
//
// Ports:
//   i_clk, i_rst - clock, asynchronous active-high reset (shared with uart_tx)
//   i_req        - per-requester request level, held until the matching o_ack
//   i_data       - packed words, requester k at [k*NBITS_D +: NBITS_D]
//   o_ack        - one-cycle pulse on bit k when requester k's frame is done
//   o_tx_start   - one-cycle start pulse to uart_tx
//   o_din        - byte to uart_tx, stable from its start pulse to the next
//   i_tx_done    - one-cycle done pulse from uart_tx
//   o_busy       - high whenever the scheduler is not idle
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int NBITS_D = 16,
    parameter int DBIT    = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*NBITS_D-1:0] i_data,
    output logic [NREQ-1:0]         o_ack,
    output logic                    o_tx_start,
    output logic [DBIT-1:0]         o_din,
    input  logic                    i_tx_done,
    output logic                    o_busy
);

    localparam int NBYTES = NBITS_D / DBIT;
`ifdef UART_ARB_CHECKSUM_EN
    localparam int NFRAME = NBYTES + 2;
`else
    localparam int NFRAME = NBYTES + 1;
`endif
    localparam int IDX_W = $clog2(NFRAME + 1);

    // Parameter sanity; the header nibble limits us to 16 requesters.
    if (NREQ < 1 || NREQ > 16) begin : g_bad_nreq
        $error("uart_tx_arbiter: NREQ must be 1..16");
    end
    if (DBIT != 8) begin : g_bad_dbit
        $error("uart_tx_arbiter: DBIT must be 8");
    end
    if (NBITS_D < DBIT || (NBITS_D % DBIT) != 0) begin : g_bad_nbits
        $error("uart_tx_arbiter: NBITS_D must be a nonzero multiple of DBIT");
    end

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    id_q;
    logic [NREQ-1:0]    gnt_q;
    logic [NBITS_D-1:0] word_q;
    logic [IDX_W-1:0]   byte_idx;
`ifdef UART_ARB_CHECKSUM_EN
    logic [DBIT-1:0]    chk_q;
`endif

    logic [NREQ-1:0]    gnt;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic [NBITS_D-1:0] gnt_word;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req     (i_req),
        .ptr     (rr_ptr),
        .grant   (gnt),
        .id      (gnt_id),
        .any_req (gnt_any)
    );

    // Word of the requester being granted this cycle, picked via the one-hot grant.
    always_comb begin
        gnt_word = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) begin
                gnt_word = i_data[k*NBITS_D +: NBITS_D];
            end
        end
    end

    assign o_busy = (state != ST_IDLE);

    // The latched word is consumed as a shift register: each data byte takes
    // the low DBIT bits, so the byte index only has to distinguish header,
    // data and (optionally) checksum positions.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            id_q       <= '0;
            gnt_q      <= '0;
            word_q     <= '0;
            byte_idx   <= '0;
            o_tx_start <= 1'b0;
            o_ack      <= '0;
            o_din      <= '0;
`ifdef UART_ARB_CHECKSUM_EN
            chk_q      <= '0;
`endif
        end else begin
            o_tx_start <= 1'b0;
            o_ack      <= '0;
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        id_q     <= gnt_id;
                        gnt_q    <= gnt;
                        word_q   <= gnt_word;
                        byte_idx <= '0;
                        state    <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    o_tx_start <= 1'b1;
                    state      <= ST_WAIT;
                    if (byte_idx == '0) begin
                        o_din <= hdr_byte(id_q);
`ifdef UART_ARB_CHECKSUM_EN
                        chk_q <= hdr_byte(id_q);
`endif
                    end
`ifdef UART_ARB_CHECKSUM_EN
                    else if (byte_idx == IDX_W'(NFRAME - 1)) begin
                        o_din <= chk_q;
                    end
`endif
                    else begin
                        o_din  <= word_q[DBIT-1:0];
                        word_q <= word_q >> DBIT;
`ifdef UART_ARB_CHECKSUM_EN
                        chk_q  <= chk_q ^ word_q[DBIT-1:0];
`endif
                    end
                end

                ST_WAIT: begin
                    if (i_tx_done) begin
                        if (byte_idx == IDX_W'(NFRAME - 1)) begin
                            o_ack <= gnt_q;
                            state <= ST_ACK;
                        end else begin
                            byte_idx <= byte_idx + IDX_W'(1);
                            state    <= ST_SEND;
                        end
                    end
                end

                ST_ACK: begin
                    // Served requester drops to lowest priority for the next pick.
                    rr_ptr <= (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
                    state  <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int NBITS_D = 16;
    localparam int DBIT    = 8;
`ifdef UART_ARB_CHECKSUM_EN
    localparam int NF = 4;
`else
    localparam int NF = 3;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ*NBITS_D-1:0] data = '0;
    logic                    model_done = 1'b0;
    logic                    stray_done = 1'b0;
    logic                    tx_done;
    logic [NREQ-1:0]         ack;
    logic                    tx_start;
    logic [DBIT-1:0]         din;
    logic                    busy;

    assign tx_done = model_done | stray_done;

    uart_tx_arbiter #(
        .NREQ    (NREQ),
        .NBITS_D (NBITS_D),
        .DBIT    (DBIT)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_data     (data),
        .o_ack      (ack),
        .o_tx_start (tx_start),
        .o_din      (din),
        .i_tx_done  (tx_done),
        .o_busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int start_total = 0;
    int ack_total   = 0;

    logic [7:0]      byte_q[$];
    int              start_cyc_q[$];
    int              done_cyc_q[$];
    logic [NREQ-1:0] ack_q[$];
    int              ack_cyc_q[$];
    logic [7:0]      exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (ack != '0) ack_total++;

    // uart_tx stand-in: logs each started byte and answers with a done pulse
    // 10 cycles after the start; a reset abandons the byte in flight.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && tx_start) begin
                int n;
                byte_q.push_back(din);
                start_cyc_q.push_back(cyc);
                start_total++;
                n = 0;
                while (n < 10 && !rst) begin
                    @(negedge clk);
                    n++;
                end
                if (!rst) begin
                    model_done = 1'b1;
                    done_cyc_q.push_back(cyc);
                    @(negedge clk);
                    model_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic clear_logs();
        byte_q.delete();
        start_cyc_q.delete();
        done_cyc_q.delete();
        ack_q.delete();
        ack_cyc_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        repeat (3) @(negedge clk);
        clear_logs();
        rst = 1'b0;
    endtask

    // Waits for n acks (bounded); optionally drops each acked request bit.
    task automatic wait_acks(input int n, input bit drop);
        int budget = 2000;
        while (ack_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (ack != '0) begin
                ack_q.push_back(ack);
                ack_cyc_q.push_back(cyc);
                if (drop) req = req & ~ack;
            end
        end
        checks++;
        if (ack_q.size() != n) begin
            errors++;
            $display("FAIL wait_acks: got %0d acks, required %0d", ack_q.size(), n);
        end
    endtask

    task automatic wait_bytes(input int n);
        int budget = 2000;
        while (byte_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (byte_q.size() < n) begin
            errors++;
            $display("FAIL wait_bytes: got %0d bytes, required %0d", byte_q.size(), n);
        end
    endtask

    task automatic check_frame(input string name, input int base);
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (byte_q[base + k] !== exp_q[k]) begin
                errors++;
                $display("FAIL %s byte %0d: got %02h, required %02h", name, k, byte_q[base + k], exp_q[k]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_start !== 1'b0) begin errors++; $display("FAIL reset tx_start: got %b, required 0", tx_start); end
        checks++;
        if (ack !== 4'b0000) begin errors++; $display("FAIL reset ack: got %b, required 0000", ack); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b, required 0", busy); end
        checks++;
        if (din !== 8'h00) begin errors++; $display("FAIL reset din: got %02h, required 00", din); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int req_cyc;
        do_reset();
        data[0*NBITS_D +: NBITS_D] = 16'h1234;
        @(negedge clk);
        req = 4'b0001;
        req_cyc = cyc;
        wait_acks(1, 1'b1);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic busy_in_ack: got %b, required 1", busy); end
        exp_q = '{8'hA0, 8'h34, 8'h12};
`ifdef UART_ARB_CHECKSUM_EN
        exp_q.push_back(8'h86);
`endif
        checks++;
        if (byte_q.size() != NF) begin errors++; $display("FAIL basic nbytes: got %0d, required %0d", byte_q.size(), NF); end
        check_frame("basic", 0);
        checks++;
        if (ack_q[0] !== 4'b0001) begin errors++; $display("FAIL basic ack: got %b, required 0001", ack_q[0]); end
        checks++;
        if (start_cyc_q[0] - req_cyc != 2) begin
            errors++; $display("FAIL basic grant_latency: got %0d, required 2", start_cyc_q[0] - req_cyc);
        end
        for (int k = 1; k < NF; k++) begin
            checks++;
            if (start_cyc_q[k] - done_cyc_q[k-1] != 2) begin
                errors++; $display("FAIL basic byte_gap %0d: got %0d, required 2", k, start_cyc_q[k] - done_cyc_q[k-1]);
            end
        end
        checks++;
        if (ack_cyc_q[0] - done_cyc_q[NF-1] != 1) begin
            errors++; $display("FAIL basic ack_latency: got %0d, required 1", ack_cyc_q[0] - done_cyc_q[NF-1]);
        end
        checks++;
        if (din !== exp_q[NF-1]) begin errors++; $display("FAIL basic din_hold: got %02h, required %02h", din, exp_q[NF-1]); end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL basic busy_idle: got %b, required 0", busy); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        data[0*NBITS_D +: NBITS_D] = 16'h0102;
        data[2*NBITS_D +: NBITS_D] = 16'h0304;
        @(negedge clk);
        req = 4'b0101;
        wait_acks(2, 1'b1);
        checks++;
        if (ack_q[0] !== 4'b0001) begin errors++; $display("FAIL simul ack0: got %b, required 0001", ack_q[0]); end
        checks++;
        if (ack_q[1] !== 4'b0100) begin errors++; $display("FAIL simul ack1: got %b, required 0100", ack_q[1]); end
        exp_q = '{8'hA0, 8'h02, 8'h01};
        check_frame("simul_f0", 0);
        exp_q = '{8'hA2, 8'h04, 8'h03};
        check_frame("simul_f1", NF);
        checks++;
        if (start_cyc_q[NF] - done_cyc_q[NF-1] < 3) begin
            errors++; $display("FAIL simul b2b_gap: got %0d, required >= 3", start_cyc_q[NF] - done_cyc_q[NF-1]);
        end
    endtask

    task automatic test_fairness();
        logic [7:0]      exp_hdr[4];
        logic [NREQ-1:0] exp_ack[4];
        exp_hdr = '{8'hA0, 8'hA1, 8'hA0, 8'hA1};
        exp_ack = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        do_reset();
        data[0*NBITS_D +: NBITS_D] = 16'h5555;
        data[1*NBITS_D +: NBITS_D] = 16'h6666;
        @(negedge clk);
        req = 4'b0011;
        wait_acks(4, 1'b0);
        req = '0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (byte_q[k*NF] !== exp_hdr[k]) begin
                errors++; $display("FAIL fair header %0d: got %02h, required %02h", k, byte_q[k*NF], exp_hdr[k]);
            end
            checks++;
            if (ack_q[k] !== exp_ack[k]) begin
                errors++; $display("FAIL fair ack %0d: got %b, required %b", k, ack_q[k], exp_ack[k]);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (byte_q.size() != 4*NF) begin
            errors++; $display("FAIL fair extra_bytes: got %0d, required %0d", byte_q.size(), 4*NF);
        end
    endtask

    task automatic test_checksum();
        do_reset();
        data[1*NBITS_D +: NBITS_D] = 16'hBEEF;
        @(negedge clk);
        req = 4'b0010;
        wait_acks(1, 1'b1);
        exp_q = '{8'hA1, 8'hEF, 8'hBE};
`ifdef UART_ARB_CHECKSUM_EN
        exp_q.push_back(8'hF0);
`endif
        checks++;
        if (byte_q.size() != NF) begin errors++; $display("FAIL chk nbytes: got %0d, required %0d", byte_q.size(), NF); end
        check_frame("chk", 0);
        checks++;
        if (ack_q[0] !== 4'b0010) begin errors++; $display("FAIL chk ack: got %b, required 0010", ack_q[0]); end
    endtask

    task automatic test_reset_mid();
        int snap;
        do_reset();
        data[0*NBITS_D +: NBITS_D] = 16'h5678;
        @(negedge clk);
        req = 4'b0001;
        wait_bytes(2);
        repeat (3) @(negedge clk);
        snap = ack_total;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy: got %b, required 0", busy); end
        checks++;
        if (din !== 8'h00) begin errors++; $display("FAIL rstmid din: got %02h, required 00", din); end
        checks++;
        if (tx_start !== 1'b0) begin errors++; $display("FAIL rstmid tx_start: got %b, required 0", tx_start); end
        checks++;
        if (ack !== 4'b0000) begin errors++; $display("FAIL rstmid ack: got %b, required 0000", ack); end
        repeat (3) @(negedge clk);
        checks++;
        if (ack_total != snap) begin errors++; $display("FAIL rstmid no_ack: got %0d acks, required %0d", ack_total, snap); end
        clear_logs();
        rst = 1'b0;
        wait_acks(1, 1'b1);
        exp_q = '{8'hA0, 8'h78, 8'h56};
        check_frame("rstmid_restart", 0);
        checks++;
        if (ack_q[0] !== 4'b0001) begin errors++; $display("FAIL rstmid ack_after: got %b, required 0001", ack_q[0]); end
    endtask

    task automatic test_done_robust();
        int snap;
        do_reset();
        snap = start_total;
        repeat (3) begin
            @(negedge clk);
            stray_done = 1'b1;
            @(negedge clk);
            stray_done = 1'b0;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (start_total != snap) begin errors++; $display("FAIL robust stray_start: got %0d starts, required %0d", start_total, snap); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL robust busy: got %b, required 0", busy); end
        data[3*NBITS_D +: NBITS_D] = 16'hCAFE;
        req = 4'b1000;
        wait_bytes(1);
        req = '0;
        wait_acks(1, 1'b0);
        checks++;
        if (ack_q[0] !== 4'b1000) begin errors++; $display("FAIL robust ack: got %b, required 1000", ack_q[0]); end
        exp_q = '{8'hA3, 8'hFE, 8'hCA};
        check_frame("robust", 0);
        repeat (10) @(negedge clk);
        checks++;
        if (byte_q.size() != NF) begin errors++; $display("FAIL robust nbytes: got %0d, required %0d", byte_q.size(), NF); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_simultaneous();
        test_fairness();
        test_checksum();
        test_reset_mid();
        test_done_robust();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
